// File: rtl/ray_dispatch_scheduler.sv
// ray_dispatch_scheduler: scans a frame, farms per-pixel ray jobs to a unit pool and drains tagged results round-robin.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 640
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 480
`endif
`ifndef H_BITS
`define H_BITS 10
`endif
`ifndef V_BITS
`define V_BITS 9
`endif
module ray_dispatch_scheduler #(
  parameter int NUM_UNITS = 4,
  parameter int DISPLAY_WIDTH = `DISPLAY_WIDTH,
  parameter int DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
  parameter int H_BITS = `H_BITS,
  parameter int V_BITS = `V_BITS,
  parameter int FP_W = 16,
  parameter int FP_FRAC = 8,
  parameter logic [FP_W-1:0] FP_PX_START = FP_W'(-((DISPLAY_WIDTH << FP_FRAC) / DISPLAY_HEIGHT)),
  parameter logic [FP_W-1:0] FP_PY_START = FP_W'(-(1 << FP_FRAC)),
  parameter logic [FP_W-1:0] FP_STEP = FP_W'((2 << FP_FRAC) / DISPLAY_HEIGHT)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start_in,
  input  logic [3*FP_W-1:0]     cam_forward_in,
  output logic                  busy_out,
  output logic                  frame_done_out,
  input  logic [NUM_UNITS-1:0]  unit_ready_in,
  output logic [NUM_UNITS-1:0]  unit_valid_out,
  output logic [H_BITS-1:0]     unit_hcount_out,
  output logic [V_BITS-1:0]     unit_vcount_out,
  output logic [FP_W-1:0]       unit_hcount_fp_out,
  output logic [FP_W-1:0]       unit_vcount_fp_out,
  output logic [3*FP_W-1:0]     unit_cam_forward_out,
  input  logic [NUM_UNITS-1:0]  unit_valid_in,
  input  logic [3*FP_W-1:0]     unit_ray_in [NUM_UNITS],
  output logic                  ray_valid_out,
  input  logic                  ray_ready_in,
  output logic [3*FP_W-1:0]     ray_direction_out,
  output logic [H_BITS-1:0]     ray_hcount_out,
  output logic [V_BITS-1:0]     ray_vcount_out
);
  localparam int PW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;
  typedef logic [NUM_UNITS-1:0] mask_t;
  typedef logic [PW-1:0] ptr_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic ptr_t first_from(input mask_t m, input ptr_t p);
    mask_t hi, src;
    first_from = '0;
    hi = m & ({NUM_UNITS{1'b1}} << p);
    src = |hi ? hi : m;
    for (int i = NUM_UNITS - 1; i >= 0; i--) if (src[i]) first_from = ptr_t'(i);
  endfunction
  function automatic ptr_t inc(input ptr_t p);
    return p == ptr_t'(NUM_UNITS - 1) ? '0 : p + 1'b1;
  endfunction
  state_t state, state_nxt;
  mask_t busy, full, elig, cap, disp_mask, pop_mask, busy_nxt, full_nxt;
  ptr_t disp_ptr, out_base, sel, out_ptr;
  logic dispatch, pop, last_col, last_pix;
  logic [H_BITS-1:0] h;
  logic [V_BITS-1:0] v;
  logic [FP_W-1:0] px, py;
  logic [3*FP_W-1:0] cam;
  logic [3*FP_W-1:0] slot_ray [NUM_UNITS];
  logic [H_BITS-1:0] slot_h [NUM_UNITS];
  logic [V_BITS-1:0] slot_v [NUM_UNITS];
  // Completion looks at the post-edge busy/full so the last pop moves straight to DONE.
  always_comb begin
    elig = unit_ready_in & ~busy & ~full;
    sel = first_from(elig, disp_ptr);
    out_ptr = first_from(full, out_base);
    dispatch = state == RUN && |elig;
    pop = |full && ray_ready_in;
    cap = unit_valid_in & busy;
    disp_mask = dispatch ? mask_t'(1) << sel : '0;
    pop_mask = pop ? mask_t'(1) << out_ptr : '0;
    busy_nxt = (busy & ~cap) | disp_mask;
    full_nxt = (full & ~pop_mask) | cap;
    last_col = h == H_BITS'(DISPLAY_WIDTH - 1);
    last_pix = last_col && v == V_BITS'(DISPLAY_HEIGHT - 1);
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = start_in ? RUN : IDLE;
      RUN:     state_nxt = dispatch && last_pix ? DRAIN : RUN;
      DRAIN:   state_nxt = ~|busy_nxt && ~|full_nxt ? DONE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      busy <= '0;
      full <= '0;
      disp_ptr <= '0;
      out_base <= '0;
      h <= '0;
      v <= '0;
      px <= '0;
      py <= '0;
      cam <= '0;
      unit_valid_out <= '0;
      unit_hcount_out <= '0;
      unit_vcount_out <= '0;
      unit_hcount_fp_out <= '0;
      unit_vcount_fp_out <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        slot_ray[i] <= '0;
        slot_h[i] <= '0;
        slot_v[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      busy <= busy_nxt;
      full <= full_nxt;
      unit_valid_out <= disp_mask;
      if (pop) out_base <= inc(out_ptr);
      if (state == IDLE && start_in) begin
        cam <= cam_forward_in;
        h <= '0;
        v <= '0;
        px <= FP_PX_START;
        py <= FP_PY_START;
      end
      if (dispatch) begin
        disp_ptr <= inc(sel);
        unit_hcount_out <= h;
        unit_vcount_out <= v;
        unit_hcount_fp_out <= px;
        unit_vcount_fp_out <= py;
        slot_h[sel] <= h;
        slot_v[sel] <= v;
        h <= last_col ? '0 : h + 1'b1;
        px <= last_col ? FP_PX_START : px + FP_STEP;
        if (last_col) begin
          v <= v + 1'b1;
          py <= py + FP_STEP;
        end
      end
      for (int i = 0; i < NUM_UNITS; i++) if (cap[i]) slot_ray[i] <= unit_ray_in[i];
    end
  end
  assign busy_out = state != IDLE;
  assign frame_done_out = state == DONE;
  assign unit_cam_forward_out = cam;
  assign ray_valid_out = |full;
  assign ray_direction_out = slot_ray[out_ptr];
  assign ray_hcount_out = slot_h[out_ptr];
  assign ray_vcount_out = slot_v[out_ptr];
endmodule

// File: tb/tb_ray_dispatch_scheduler.sv
// tb_ray_dispatch_scheduler: random-latency unit models and a pixel-set scoreboard around a 2-unit, 4x2 scheduler.
module tb_ray_dispatch_scheduler;
  localparam int N = 2, W = 4, H = 2;
  localparam real PX0 = -4.0 / 2.0, PY0 = -1.0, STEP = 2.0 / 2.0;
  logic clk_in = 0, rst_n_in = 0, start_in = 0, ray_ready_in = 1;
  logic [47:0] cam_forward_in = '0, cam_ref = '0;
  logic [N-1:0] unit_ready_in = '1, unit_valid_out, unit_valid_in, uv_model = '0, spur = '0;
  logic [1:0] unit_hcount_out, ray_hcount_out;
  logic [0:0] unit_vcount_out, ray_vcount_out;
  logic [15:0] unit_hcount_fp_out, unit_vcount_fp_out;
  logic [47:0] unit_cam_forward_out, ray_direction_out;
  logic [47:0] unit_ray_in [N];
  logic busy_out, frame_done_out, ray_valid_out;
  int vectors = 0, miscompares = 0;
  int cnt [N];
  int lat = 5, cyc = 0;
  bit lat_rand = 0, rr_hold = 0, rr_pulse = 0, rr_rand = 0, gate_mode = 0, ur_rand = 0;
  int seen [W][H];
  int pix_unit [W][H];
  int pop_bad, disp_bad, done_cnt, n_disp, n_pop, max_out;
  int dq_u[$], dq_h[$], dq_v[$], pop_u[$];
  logic [15:0] dq_px[$], dq_py[$];

  assign unit_valid_in = uv_model | spur;
  always #5 clk_in = ~clk_in;

  ray_dispatch_scheduler #(.NUM_UNITS(N), .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .H_BITS(2), .V_BITS(1),
    .FP_W(16), .FP_FRAC(8)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .cam_forward_in(cam_forward_in),
    .busy_out(busy_out), .frame_done_out(frame_done_out), .unit_ready_in(unit_ready_in),
    .unit_valid_out(unit_valid_out), .unit_hcount_out(unit_hcount_out), .unit_vcount_out(unit_vcount_out),
    .unit_hcount_fp_out(unit_hcount_fp_out), .unit_vcount_fp_out(unit_vcount_fp_out),
    .unit_cam_forward_out(unit_cam_forward_out), .unit_valid_in(unit_valid_in), .unit_ray_in(unit_ray_in),
    .ray_valid_out(ray_valid_out), .ray_ready_in(ray_ready_in), .ray_direction_out(ray_direction_out),
    .ray_hcount_out(ray_hcount_out), .ray_vcount_out(ray_vcount_out));

  function automatic logic [15:0] px_of(int hh);
    return 16'(int'(PX0 * 256.0) + hh * int'(STEP * 256.0));
  endfunction
  function automatic logic [15:0] py_of(int vv);
    return 16'(int'(PY0 * 256.0) + vv * int'(STEP * 256.0));
  endfunction
  function automatic logic [47:0] exp_ray(int hh, int vv);
    return {16'(hh * 37 + vv * 11) ^ cam_ref[15:0], px_of(hh), py_of(vv)};
  endfunction
  function automatic int frame_errs();
    int e = pop_bad + disp_bad;
    for (int a = 0; a < W; a++) for (int b = 0; b < H; b++) e += int'(seen[a][b] != 1);
    return e;
  endfunction

  always @(negedge clk_in) begin
    cyc++;
    ray_ready_in = rr_rand ? 1'($urandom) : !(rr_hold && !rr_pulse);
    unit_ready_in = ur_rand ? N'($urandom) : gate_mode ? {N{cyc % 4 == 0}} : '1;
    if (!rst_n_in) begin
      uv_model = '0;
      for (int i = 0; i < N; i++) begin cnt[i] = 0; unit_ray_in[i] = '0; end
    end else begin
      for (int i = 0; i < N; i++) begin
        uv_model[i] = 1'b0;
        if (cnt[i] > 0) begin cnt[i]--; if (cnt[i] == 0) uv_model[i] = 1'b1; end
      end
      if ($countones(unit_valid_out) > 1) disp_bad++;
      for (int i = 0; i < N; i++) if (unit_valid_out[i]) begin
        unit_ray_in[i] = {16'(int'(unit_hcount_out) * 37 + int'(unit_vcount_out) * 11) ^ unit_cam_forward_out[15:0],
                          unit_hcount_fp_out, unit_vcount_fp_out};
        cnt[i] = lat_rand ? int'($urandom_range(1, 6)) : lat;
        pix_unit[unit_hcount_out][unit_vcount_out] = i;
        dq_u.push_back(i); dq_h.push_back(int'(unit_hcount_out)); dq_v.push_back(int'(unit_vcount_out));
        dq_px.push_back(unit_hcount_fp_out); dq_py.push_back(unit_vcount_fp_out);
        n_disp++;
      end
      if (ray_valid_out && ray_ready_in) begin
        seen[ray_hcount_out][ray_vcount_out]++;
        if (ray_direction_out !== exp_ray(int'(ray_hcount_out), int'(ray_vcount_out))) pop_bad++;
        pop_u.push_back(pix_unit[ray_hcount_out][ray_vcount_out]);
        n_pop++;
      end
      if (n_disp - n_pop > max_out) max_out = n_disp - n_pop;
      if (frame_done_out) done_cnt++;
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk_in); #2; end
  endtask
  task automatic clear_logs();
    seen = '{default: 0}; pix_unit = '{default: 0};
    pop_bad = 0; disp_bad = 0; done_cnt = 0; n_disp = 0; n_pop = 0; max_out = 0;
    dq_u.delete(); dq_h.delete(); dq_v.delete(); dq_px.delete(); dq_py.delete(); pop_u.delete();
  endtask
  task automatic start_frame();
    cam_forward_in = {16'($urandom), 32'($urandom)};
    cam_ref = cam_forward_in;
    start_in = 1;
    tick(1);
    start_in = 0;
  endtask
  task automatic wait_done(output bit ok);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) tick(1);
    ok = done_cnt > 0;
    tick(3);
  endtask

  task automatic test_reset();
    tick(2);
    vectors++; if (busy_out !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0h want 0", busy_out); end
    vectors++; if (unit_valid_out !== '0) begin miscompares++; $display("FAIL reset_unit_valid got %0h want 0", unit_valid_out); end
    vectors++; if (ray_valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_ray_valid got %0h want 0", ray_valid_out); end
    vectors++; if (frame_done_out !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0h want 0", frame_done_out); end
    vectors++; if ({ray_direction_out, unit_cam_forward_out, unit_hcount_fp_out} !== '0) begin
      miscompares++; $display("FAIL reset_data got %0h want 0", {ray_direction_out, unit_cam_forward_out, unit_hcount_fp_out}); end
    rst_n_in = 1;
    tick(2);
  endtask

  task automatic test_basic_frame();
    bit ok;
    lat = 5; clear_logs(); start_frame();
    vectors++; if (busy_out !== 1'b1) begin miscompares++; $display("FAIL start_busy got %0h want 1", busy_out); end
    vectors++; if (unit_valid_out !== 2'b00) begin miscompares++; $display("FAIL start_no_disp got %0h want 0", unit_valid_out); end
    tick(1);
    vectors++; if ({unit_valid_out, unit_hcount_out, unit_vcount_out} !== {2'b01, 2'd0, 1'b0}) begin
      miscompares++; $display("FAIL first_dispatch got %0h want %0h", {unit_valid_out, unit_hcount_out, unit_vcount_out}, {2'b01, 3'd0}); end
    wait_done(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL basic_timeout got 0 want 1"); end
    vectors++; if (frame_errs() !== 0) begin miscompares++; $display("FAIL basic_pixels got %0d want 0 errors", frame_errs()); end
    vectors++; if (n_pop !== 8) begin miscompares++; $display("FAIL basic_count got %0d want 8", n_pop); end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt); end
    vectors++; if (busy_out !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after got %0h want 0", busy_out); end
  endtask

  task automatic test_fp_scan();
    vectors++; if (dq_px.size() !== 8) begin miscompares++; $display("FAIL fp_log_size got %0d want 8", dq_px.size()); end
    if (dq_px.size() >= 5) begin
      for (int k = 0; k < 4; k++) begin
        vectors++; if ({dq_px[k], dq_py[k]} !== {px_of(k), py_of(0)}) begin
          miscompares++; $display("FAIL fp_row0_k%0d got %0h want %0h", k, {dq_px[k], dq_py[k]}, {px_of(k), py_of(0)}); end
      end
      vectors++; if ({dq_h[4], dq_v[4]} !== {0, 1}) begin miscompares++; $display("FAIL fp_row1_tag got %0d,%0d want 0,1", dq_h[4], dq_v[4]); end
      vectors++; if ({dq_px[4], dq_py[4]} !== {px_of(0), py_of(1)}) begin
        miscompares++; $display("FAIL fp_row1 got %0h want %0h", {dq_px[4], dq_py[4]}, {px_of(0), py_of(1)}); end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    gate_mode = 1; lat = 1; clear_logs(); start_frame(); wait_done(ok); gate_mode = 0;
    vectors++; if (!ok || frame_errs() !== 0) begin miscompares++; $display("FAIL rr_frame got ok=%0d err=%0d want 1,0", ok, frame_errs()); end
    for (int k = 1; k < 4 && k < dq_u.size(); k++) begin
      vectors++; if (dq_u[k] === dq_u[k-1]) begin miscompares++; $display("FAIL rr_dispatch_%0d got unit %0d want unit %0d", k, dq_u[k], 1 - dq_u[k-1]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    rr_hold = 1; lat = 3; clear_logs(); start_frame(); tick(50);
    vectors++; if ({ray_valid_out, n_disp, n_pop} !== {1'b1, 2, 0}) begin
      miscompares++; $display("FAIL bp_stall got valid=%0d disp=%0d pop=%0d want 1,2,0", ray_valid_out, n_disp, n_pop); end
    repeat (4) begin rr_pulse = 1; tick(1); rr_pulse = 0; tick(20); end
    vectors++; if (n_pop !== 4) begin miscompares++; $display("FAIL bp_pulse_pops got %0d want 4", n_pop); end
    for (int k = 1; k < 4 && k < pop_u.size(); k++) begin
      vectors++; if (pop_u[k] === pop_u[k-1]) begin miscompares++; $display("FAIL bp_out_rr_%0d got unit %0d want unit %0d", k, pop_u[k], 1 - pop_u[k-1]); end
    end
    rr_hold = 0; wait_done(ok);
    vectors++; if (!ok || frame_errs() !== 0 || n_pop !== 8) begin
      miscompares++; $display("FAIL bp_drain got ok=%0d err=%0d pops=%0d want 1,0,8", ok, frame_errs(), n_pop); end
    vectors++; if (max_out > 2) begin miscompares++; $display("FAIL bp_outstanding got %0d want <=2", max_out); end
  endtask

  task automatic test_spurious();
    bit ok;
    spur = 2'b10; tick(1); spur = '0; tick(1);
    vectors++; if ({ray_valid_out, busy_out} !== 2'b00) begin miscompares++; $display("FAIL spur_capture got %0b want 00", {ray_valid_out, busy_out}); end
    lat = 4; clear_logs(); start_frame(); tick(4);
    start_in = 1; tick(1); start_in = 0;
    wait_done(ok);
    vectors++; if (!ok || frame_errs() !== 0) begin miscompares++; $display("FAIL restart_pixels got ok=%0d err=%0d want 1,0", ok, frame_errs()); end
    vectors++; if ({n_disp, n_pop, done_cnt} !== {8, 8, 1}) begin
      miscompares++; $display("FAIL restart_counts got %0d/%0d/%0d want 8/8/1", n_disp, n_pop, done_cnt); end
  endtask

  task automatic test_async_reset();
    bit ok;
    lat = 4; clear_logs(); start_frame();
    for (int i = 0; i < 100 && n_disp < 3; i++) tick(1);
    vectors++; if (n_disp < 3) begin miscompares++; $display("FAIL ar_dispatches got %0d want 3", n_disp); end
    #1 rst_n_in = 0;
    #1;
    vectors++; if ({busy_out, frame_done_out, ray_valid_out, unit_valid_out} !== '0) begin
      miscompares++; $display("FAIL ar_ctrl got %0b want 0", {busy_out, frame_done_out, ray_valid_out, unit_valid_out}); end
    vectors++; if ({ray_direction_out, ray_hcount_out, unit_hcount_out, unit_hcount_fp_out, unit_vcount_fp_out, unit_cam_forward_out} !== '0) begin
      miscompares++; $display("FAIL ar_data got nonzero %0h want 0", {ray_direction_out, unit_hcount_fp_out, unit_cam_forward_out}); end
    tick(2); rst_n_in = 1; tick(1);
    clear_logs(); start_frame(); wait_done(ok);
    vectors++; if (!ok || frame_errs() !== 0 || n_pop !== 8) begin
      miscompares++; $display("FAIL ar_frame got ok=%0d err=%0d pops=%0d want 1,0,8", ok, frame_errs(), n_pop); end
    if (dq_u.size() > 0) begin
      vectors++; if ({dq_u[0], dq_h[0], dq_v[0]} !== {0, 0, 0}) begin
        miscompares++; $display("FAIL ar_first got u%0d (%0d,%0d) want u0 (0,0)", dq_u[0], dq_h[0], dq_v[0]); end
    end
  endtask

  task automatic test_random_frames();
    bit ok;
    for (int f = 0; f < 4; f++) begin
      rr_rand = 1; ur_rand = f[0]; lat_rand = 1;
      clear_logs(); start_frame(); wait_done(ok);
      rr_rand = 0; ur_rand = 0; lat_rand = 0; tick(2);
      vectors++; if (!ok || frame_errs() !== 0 || n_pop !== 8 || done_cnt !== 1) begin
        miscompares++; $display("FAIL rand_frame%0d got ok=%0d err=%0d pops=%0d done=%0d want 1,0,8,1", f, ok, frame_errs(), n_pop, done_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_fp_scan();
    test_round_robin();
    test_backpressure();
    test_spurious();
    test_async_reset();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ray_dispatch_scheduler.md
# ray_dispatch_scheduler

Frame-level scheduler that scans every pixel of the display and dispatches per-pixel ray-generation jobs to a pool of `NUM_UNITS` multi-cycle ray generator units. It tracks which units are busy, captures each unit's result with its pixel tag into a per-unit slot, and drains the slots to one downstream valid/ready consumer in round-robin order. It sits between the frame controller (start/done) and the ray marcher input stage.

## Interface
- `NUM_UNITS`, 4: number of ray generator units, 1..8.
- `DISPLAY_WIDTH`, `` `DISPLAY_WIDTH ``: pixels per row.
- `DISPLAY_HEIGHT`, `` `DISPLAY_HEIGHT ``: rows per frame.
- `H_BITS`, `` `H_BITS ``: hcount width.
- `V_BITS`, `` `V_BITS ``: vcount width.
- `FP_PX_START`, `-DISPLAY_WIDTH/DISPLAY_HEIGHT` as fp: px for column 0.
- `FP_PY_START`, `-1.0` as fp: py for row 0.
- `FP_STEP`, `2/DISPLAY_HEIGHT` as fp: px/py increment per column/row.

Ports:
- `clk_in` in 1: clock.
- `rst_n_in` in 1: reset, asynchronous, active-low.
- `start_in` in 1: begin a frame; sampled only in IDLE.
- `cam_forward_in` in vec3: camera forward; latched on accepted start.
- `busy_out` out 1: high from accepted start until DONE exits.
- `frame_done_out` out 1: one-cycle pulse when the last result has been handed off.
- `unit_ready_in` in NUM_UNITS: per-unit ready.
- `unit_valid_out` out NUM_UNITS: per-unit job strobe, at most one bit high.
- `unit_hcount_out` out H_BITS: shared job pixel x.
- `unit_vcount_out` out V_BITS: shared job pixel y.
- `unit_hcount_fp_out` out fp: shared job px.
- `unit_vcount_fp_out` out fp: shared job py.
- `unit_cam_forward_out` out vec3: latched camera forward.
- `unit_valid_in` in NUM_UNITS: per-unit result strobe.
- `unit_ray_in[NUM_UNITS]` in vec3 array: per-unit result direction.
- `ray_valid_out` out 1: downstream result valid.
- `ray_ready_in` in 1: downstream ready.
- `ray_direction_out` out vec3: result direction.
- `ray_hcount_out` out H_BITS: result pixel x.
- `ray_vcount_out` out V_BITS: result pixel y.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: when `start_in` is high, latch `cam_forward_in` and set h=0, v=0, px=FP_PX_START, py=FP_PY_START. Next state is RUN.
- RUN dispatch:
  - Unit i is eligible when `unit_ready_in[i]` is high, `busy[i]` is 0 and `full[i]` is 0.
  - A round-robin pointer selects the first eligible unit at or after `disp_ptr`.
  - The dispatch registers unit_valid_out one-hot together with h, v, px, py.
  - It sets `busy[i]` and stores tag (h, v) in slot i.
  - `disp_ptr` moves to i+1 mod NUM_UNITS.
- Scan advance, per dispatch:
  - Normally h+1 and px = fp_add(px, FP_STEP).
  - At h = DISPLAY_WIDTH-1: h=0, px=FP_PX_START, v+1, py = fp_add(py, FP_STEP).
  - The dispatch of pixel (W-1, H-1) moves the state to DRAIN.
- Result capture: when `unit_valid_in[i]` is high and `busy[i]` is 1, store the ray in slot i, set `full[i]` and clear `busy[i]`. `unit_valid_in[i]` with `busy[i]` at 0 is ignored.
- Output path:
  - `ray_valid_out` = |full.
  - Outputs show slot `out_ptr`, which is the first full slot at or after the last served slot plus one.
  - On `ray_valid_out && ray_ready_in`, clear `full[out_ptr]`. The pointer advances.
- DRAIN: no dispatches. When all busy and full bits are 0, the next state is DONE.
- DONE: assert `frame_done_out` for one cycle. Next state is IDLE.
- Results leave out of pixel order. The tags identify each pixel.
- `start_in` outside IDLE is ignored. There is no abort; reset is the only way to stop a frame.
- fp adds wrap according to the fp format. The block does no saturation.

## Timing
- Reset values:
  - state = IDLE.
  - All `unit_valid_out` = 0, `busy_out` = 0, `frame_done_out` = 0, `ray_valid_out` = 0.
  - busy = 0, full = 0, disp_ptr = 0, out_ptr = 0.
  - h, v, px, py, latched cam_forward and the data outputs = 0.
- Reset is asynchronous. Asserting it mid-frame clears everything immediately. Any in-flight unit results are dropped, because busy = 0.
- Start: `start_in` high at edge t gives RUN and `busy_out` = 1 from t+1. The first dispatch can be registered at edge t+1, so `unit_valid_out` is visible in cycle t+1..t+2.
- Dispatch: eligibility is sampled at edge t, and `unit_valid_out[i]` is high for exactly the cycle after edge t. Peak rate is one job per cycle.
- A unit cannot be re-dispatched while it is busy. This covers the window where the unit's ready has not yet fallen.
- Capture: `unit_valid_in[i]` at edge t gives `full[i]` = 1 and `ray_valid_out` = 1 from t+1.
- Same-cycle events are independent:
  - a dispatch to unit j, a capture from unit k and an output pop of slot m can all occur in one cycle;
  - a slot popped at edge t is eligible again at edge t+1.
- Completion: the last pop at edge t gives DONE at t+1, a `frame_done_out` pulse in cycle t+1, IDLE at t+2 and `busy_out` = 0 from t+2.

## Test plan
- **Basic frame.** NUM_UNITS=2, 4x2 display; units always ready with fixed 5-cycle latency; `ray_ready_in`=1.
  - Exactly 8 results, each (h, v) in {0..3}x{0..1} exactly once.
  - One `frame_done_out` pulse. `busy_out` low afterwards.
- **Fp scan.**
  - Row 0: check the px sequence FP_PX_START + k·FP_STEP for k=0..3.
  - Row 1: py = FP_PY_START + FP_STEP and px restarts at FP_PX_START at h=0.
- **Backpressure.** Hold `ray_ready_in`=0 for 50 cycles mid-frame.
  - At most 2 dispatches are outstanding. Both slots become full and dispatch stops.
  - After release, all results drain and the frame completes without loss or duplicates.
- **Round-robin fairness.** Both units are eligible on the same cycles.
  - Dispatches alternate unit 0, 1, 0, 1.
  - With both slots full, output alternates.
- **Spurious and ignored strobes.**
  - `unit_valid_in[1]` while unit 1 is idle: no capture.
  - `start_in` pulsed during RUN: no restart and the tags are unchanged.
- **Async reset mid-frame.** Drop `rst_n_in` between clock edges after 3 dispatches.
  - All outputs are 0 immediately.
  - A fresh `start_in` yields a full 8-pixel frame beginning at (0, 0).
